// File: rtl/cada_ctx_pe.sv
// rtl/cada_ctx_pe.sv - multi-context processing element with two-stage elastic pipeline and feedback accumulator
// Optional saturation of ADD/SUB/ADD3/MAC is enabled by defining CADA_PE_SAT_EN.
module cada_ctx_pe #(
   parameter int DATA_BW = 32,
   parameter int NUM_CTX = 4,
   parameter int CTX_BW  = $clog2(NUM_CTX),
   parameter int INST_BW = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_BW-1:0] in_a,
   input  logic [DATA_BW-1:0] in_b,
   input  logic [DATA_BW-1:0] in_c,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [DATA_BW-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   input  logic               cfg_we,
   input  logic [CTX_BW-1:0]  cfg_addr,
   input  logic [INST_BW-1:0] cfg_data,
   input  logic               ctx_switch,
   input  logic [CTX_BW-1:0]  ctx_sel,
   input  logic               acc_clr,
   output logic [CTX_BW-1:0]  ctx_active
);

   localparam int WB     = DATA_BW + 2;
   localparam int OPC_BW = 5;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_MAC  = 3'b011;
   localparam logic [2:0] OP_ADD3 = 3'b100;
   localparam logic [2:0] OP_PASS = 3'b101;

   logic [OPC_BW-1:0]  ctxMem [NUM_CTX];

   logic               s1Valid;
   logic [DATA_BW-1:0] s1A;
   logic [DATA_BW-1:0] s1B;
   logic [DATA_BW-1:0] s1C;
   logic [OPC_BW-1:0]  s1Inst;

   logic [DATA_BW-1:0] acc;

   logic               s2Free;
   logic               accept;
   logic               s2Load;

   logic [DATA_BW-1:0] accEff;
   logic [DATA_BW-1:0] opA;
   logic [DATA_BW-1:0] prod;
   logic [WB-1:0]      sumAdd;
   logic [WB-1:0]      sumSub;
   logic [WB-1:0]      sumAdd3;
   logic [WB-1:0]      sumMac;
   logic [DATA_BW-1:0] resAdd;
   logic [DATA_BW-1:0] resSub;
   logic [DATA_BW-1:0] resAdd3;
   logic [DATA_BW-1:0] resMac;
   logic [DATA_BW-1:0] result;

   logic               unusedCfg;

   function automatic logic [WB-1:0] sx(input logic [DATA_BW-1:0] v);
      return {{2{v[DATA_BW-1]}}, v};
   endfunction

   assign s2Free   = ~out_valid | out_ready;
   assign in_ready = ~s1Valid | s2Free;
   assign accept   = in_valid & in_ready;
   assign s2Load   = s1Valid & s2Free;

   // Reserved instruction bits are never stored.
   assign unusedCfg = ^cfg_data[INST_BW-1:OPC_BW];

   // A clear in the same cycle as an S2 load makes that beat see acc = 0.
   always_comb begin
      accEff  = acc_clr ? '0 : acc;
      opA     = s1Inst[4] ? accEff : s1A;
      prod    = opA * s1B;
      sumAdd  = sx(opA) + sx(s1B);
      sumSub  = sx(opA) - sx(s1B);
      sumAdd3 = sx(opA) + sx(s1B) + sx(s1C);
      sumMac  = sx(accEff) + sx(prod);
   end

`ifdef CADA_PE_SAT_EN
   function automatic logic [DATA_BW-1:0] clampRes(input logic [WB-1:0] w);
      logic signed [WB-1:0] sw;
      logic signed [WB-1:0] maxV;
      logic signed [WB-1:0] minV;
      sw   = w;
      maxV = {3'b000, {(DATA_BW-1){1'b1}}};
      minV = {3'b111, {(DATA_BW-1){1'b0}}};
      if (sw > maxV)
         return maxV[DATA_BW-1:0];
      else if (sw < minV)
         return minV[DATA_BW-1:0];
      else
         return w[DATA_BW-1:0];
   endfunction

   assign resAdd  = clampRes(sumAdd);
   assign resSub  = clampRes(sumSub);
   assign resAdd3 = clampRes(sumAdd3);
   assign resMac  = clampRes(sumMac);
`else
   logic unusedWide;

   assign resAdd  = sumAdd[DATA_BW-1:0];
   assign resSub  = sumSub[DATA_BW-1:0];
   assign resAdd3 = sumAdd3[DATA_BW-1:0];
   assign resMac  = sumMac[DATA_BW-1:0];
   assign unusedWide = ^{sumAdd[WB-1:DATA_BW], sumSub[WB-1:DATA_BW],
                         sumAdd3[WB-1:DATA_BW], sumMac[WB-1:DATA_BW]};
`endif

   always_comb begin
      result = '0;
      case (s1Inst[2:0])
         OP_ADD:  result = resAdd;
         OP_SUB:  result = resSub;
         OP_MUL:  result = prod;
         OP_MAC:  result = resMac;
         OP_ADD3: result = resAdd3;
         OP_PASS: result = opA;
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CTX; i++)
            ctxMem[i] <= '0;
         ctx_active <= '0;
      end else begin
         if (cfg_we)
            ctxMem[cfg_addr] <= cfg_data[OPC_BW-1:0];
         if (ctx_switch)
            ctx_active <= ctx_sel;
      end
   end

   // The instruction is bound here, so later cfg/switch never touch in-flight beats.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1Valid <= 1'b0;
         s1A     <= '0;
         s1B     <= '0;
         s1C     <= '0;
         s1Inst  <= '0;
      end else if (accept) begin
         s1Valid <= 1'b1;
         s1A     <= in_a;
         s1B     <= ctxMem[ctx_active][3] ? in_c : in_b;
         s1C     <= in_c;
         s1Inst  <= ctxMem[ctx_active];
      end else if (s2Load) begin
         s1Valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         acc       <= '0;
      end else begin
         if (s2Load) begin
            out_valid <= 1'b1;
            out_data  <= result;
            acc       <= result;
         end else begin
            if (out_ready)
               out_valid <= 1'b0;
            if (acc_clr)
               acc <= '0;
         end
      end
   end

endmodule
